// File: rtl/arb_pkg.sv
// Shared FSM encoding and width helper for the round-robin event arbiter.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_event_arbiter_pick.sv
// Round-robin pick: first set pending bit scanning ptr, ptr+1, .. mod N.
// Purely combinational; no handshake, result valid whenever any=1.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  // rot[i] is the pending bit i places after ptr; W-bit adds wrap mod N
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = pending[ptr + W'(i)];
    end
  end

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
  end

  assign any = |pending;
  assign idx = ptr + off;

  always_comb begin
    onehot = '0;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_event_arbiter.sv
// Latches request events and presents one round-robin grant as a one-hot vector.
// Event to grant in 2 cycles; grant held until gnt_ack, new events only accumulate.
module rr_event_arbiter
  import arb_pkg::*;
#(
  parameter int N         = 8,
  parameter int EDGE_MODE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt_onehot,
  output logic         gnt_valid,
  input  logic         gnt_ack,
  output logic [N-1:0] pending,
  output logic         ovf,
  input  logic         clr_ovf
);

  localparam int W = clog2(N);

  state_e       state_q, state_d;
  logic [N-1:0] req_d_q, req_d_d;
  logic [N-1:0] pending_q, pending_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] gnt_onehot_q, gnt_onehot_d;
  logic         gnt_valid_q, gnt_valid_d;
  logic [W-1:0] gnt_idx_q, gnt_idx_d;

  logic [N-1:0] ev;
  logic [N-1:0] clr_mask;
  logic         ack_fire;
  logic [N-1:0] pick_onehot;
  logic [W-1:0] pick_idx;
  logic         pick_any;

  rr_pick #(.N(N), .W(W)) u_pick (
    .pending (pending_q),
    .ptr     (ptr_q),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  // A new event on the bit being acked re-arms it rather than counting as overflow
  always_comb begin
    ev        = (EDGE_MODE != 0) ? (req & ~req_d_q) : req;
    ack_fire  = (state_q == ST_GRANT) && gnt_ack;
    clr_mask  = ack_fire ? gnt_onehot_q : '0;
    req_d_d   = req;
    pending_d = (pending_q & ~clr_mask) | ev;
    ovf_d     = ovf_q;
    if (|(ev & pending_q & ~clr_mask)) ovf_d = 1'b1;
    else if (clr_ovf)                  ovf_d = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    gnt_onehot_d = gnt_onehot_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    ptr_d        = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_onehot_d = pick_onehot;
          gnt_valid_d  = 1'b1;
          gnt_idx_d    = pick_idx;
          state_d      = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (gnt_ack) begin
          ptr_d        = gnt_idx_q + W'(1);
          gnt_onehot_d = '0;
          gnt_valid_d  = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_d_q      <= '0;
      pending_q    <= '0;
      ovf_q        <= 1'b0;
      ptr_q        <= '0;
      gnt_onehot_q <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_d_q      <= req_d_d;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      ptr_q        <= ptr_d;
      gnt_onehot_q <= gnt_onehot_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
    end
  end

  assign gnt_onehot = gnt_onehot_q;
  assign gnt_valid  = gnt_valid_q;
  assign pending    = pending_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_rr_event_arbiter.sv
// Scoreboarded bench for rr_event_arbiter: reference model queues expected grants, monitor pops them.
module tb_rr_event_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         gnt_ack = 1'b0;
  logic         clr_ovf = 1'b0;
  logic [N-1:0] gnt_onehot;
  logic         gnt_valid;
  logic [N-1:0] pending;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  rr_event_arbiter #(.N(N), .EDGE_MODE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_onehot (gnt_onehot),
    .gnt_valid  (gnt_valid),
    .gnt_ack    (gnt_ack),
    .pending    (pending),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-line pending flags, pointer and granted line (-1 when none)
  int m_pend[N];
  int m_prev[N];
  int m_ptr;
  int m_gnt;
  int m_ovf;
  int exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_prev[i] = 0;
    end
    m_ptr = 0;
    m_gnt = -1;
    m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic a, input logic c);
    int ev[N];
    int hit;
    int acked;
    int pick;
    acked = (m_gnt >= 0 && a) ? 1 : 0;
    hit   = 0;
    for (int i = 0; i < N; i++) begin
      ev[i]     = (r[i] && m_prev[i] == 0) ? 1 : 0;
      m_prev[i] = r[i] ? 1 : 0;
      if (ev[i] != 0 && m_pend[i] != 0 && !(acked != 0 && m_gnt == i)) hit = 1;
    end
    pick = -1;
    if (m_gnt < 0) begin
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && m_pend[(m_ptr + k) % N] != 0) pick = (m_ptr + k) % N;
      end
    end
    if (acked != 0) begin
      m_pend[m_gnt] = 0;
      m_ptr         = (m_gnt + 1) % N;
      m_gnt         = -1;
    end else if (pick >= 0) begin
      m_gnt = pick;
      exp_q.push_back(pick);
    end
    for (int i = 0; i < N; i++) begin
      if (ev[i] != 0) m_pend[i] = 1;
    end
    if (hit != 0) m_ovf = 1;
    else if (c)   m_ovf = 0;
  endtask

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_pend[i] != 0);
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step(req, gnt_ack, clr_ovf);
    end
  end

  // Monitor: invariants, model state and grant scoreboard, sampled on the falling edge
  initial begin
    logic         pv;
    logic [N-1:0] pg;
    int           e;
    pv = 1'b0;
    pg = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_gnt", 32'(gnt_onehot), 32'h0);
        chk("rst_vld", 32'(gnt_valid), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        pv = 1'b0;
      end else begin
        chk("onehot0", 32'($onehot0(gnt_onehot)), 32'h1);
        chk("vld_eq_any", 32'(gnt_valid), 32'(|gnt_onehot));
        chk("pending", 32'(pending), 32'(m_pend_vec()));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (gnt_valid && !pv) begin
          if (exp_q.size() == 0) begin
            chk("grant_unexpected", 32'(gnt_onehot), 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("grant", 32'(gnt_onehot), 32'(1 << e));
          end
        end else if (gnt_valid && pv) begin
          chk("grant_hold", 32'(gnt_onehot), 32'(pg));
        end
        pv = gnt_valid;
        pg = gnt_onehot;
      end
    end
  end

  task automatic step(input logic [N-1:0] r, input logic a, input logic c);
    @(negedge clk);
    req     = r;
    gnt_ack = a;
    clr_ovf = c;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    @(negedge clk);
    rst     = 1'b1;
    req     = r;
    gnt_ack = 1'b0;
    clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] seq_a[4];
    logic [N-1:0] seq_b[2];
    int           guard;
    seq_a = '{8'h02, 8'h08, 8'h20, 8'h80};
    seq_b = '{8'h01, 8'h80};

    // Reset with all requests high, then release: everything latches as edges
    do_reset(8'hFF);
    step(8'hFF, 1'b0, 1'b0);
    chk("t1_pend", 32'(pending), 32'hFF);
    chk("t1_idle", 32'(gnt_valid), 32'h0);
    step(8'hFF, 1'b0, 1'b0);
    chk("t1_first_gnt", 32'(gnt_onehot), 32'h01);

    // Latency and grant hold under backpressure
    do_reset(8'h00);
    step(8'h08, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("t2_pend", 32'(pending), 32'h08);
    chk("t2_vld0", 32'(gnt_valid), 32'h0);
    step(8'h00, 1'b0, 1'b0);
    chk("t2_gnt", 32'(gnt_onehot), 32'h08);
    for (int i = 0; i < 20; i++) step((i == 5) ? 8'h40 : 8'h00, 1'b0, 1'b0);
    chk("t2_hold", 32'(gnt_onehot), 32'h08);
    chk("t2_pend48", 32'(pending), 32'h48);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("t2_ack_vld", 32'(gnt_valid), 32'h0);
    chk("t2_ack_pend", 32'(pending), 32'h40);
    step(8'h00, 1'b0, 1'b0);
    chk("t2_gnt40", 32'(gnt_onehot), 32'h40);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // Fairness and pointer wrap
    do_reset(8'h00);
    step(8'hAA, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(8'h00, 1'b1, 1'b0);
      chk("t3_rr", 32'(gnt_onehot), 32'(seq_a[k]));
      step(8'h00, 1'b0, 1'b0);
      chk("t3_gap", 32'(gnt_valid), 32'h0);
    end
    step(8'h81, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(8'h00, 1'b1, 1'b0);
      chk("t3_wrap", 32'(gnt_onehot), 32'(seq_b[k]));
      step(8'h00, 1'b0, 1'b0);
    end

    // Overflow: sticky, cleared by clr_ovf, set beats clear
    do_reset(8'h00);
    step(8'h02, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h02, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("t4_ovf_set", 32'(ovf), 32'h1);
    repeat (3) step(8'h00, 1'b0, 1'b0);
    chk("t4_ovf_sticky", 32'(ovf), 32'h1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    chk("t4_ovf_clr", 32'(ovf), 32'h0);
    step(8'h02, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    chk("t4_set_wins", 32'(ovf), 32'h1);

    // Event on the line being acked stays pending without overflow
    do_reset(8'h00);
    step(8'h04, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("t5_gnt", 32'(gnt_onehot), 32'h04);
    step(8'h04, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("t5_vld0", 32'(gnt_valid), 32'h0);
    chk("t5_pend", 32'(pending), 32'h04);
    chk("t5_no_ovf", 32'(ovf), 32'h0);
    step(8'h00, 1'b0, 1'b0);
    chk("t5_regrant", 32'(gnt_onehot), 32'h04);

    // Asynchronous reset in the middle of a grant
    do_reset(8'h00);
    step(8'h30, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("t6_gnt", 32'(gnt_onehot), 32'h10);
    chk("t6_pend", 32'(pending), 32'h30);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_gnt", 32'(gnt_onehot), 32'h0);
    chk("t6_async_vld", 32'(gnt_valid), 32'h0);
    chk("t6_async_pend", 32'(pending), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) step(8'h00, 1'b0, 1'b0);
    chk("t6_no_grant", 32'(gnt_valid), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0));
    end

    guard = 0;
    while ((m_gnt >= 0 || m_pend_vec() != '0) && guard < 200) begin
      step(8'h00, 1'b1, 1'b0);
      guard++;
    end
    chk("drain_bound", 32'(guard < 200), 32'h1);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
